// File: rtl/prefetch_issue_scheduler.sv
// Next-line prefetch scheduler: expands dcache misses into page-bounded
// line candidates, dedups them, queues them and issues under MSHR/gap limits.
module prefetch_issue_scheduler #(
  parameter int ADDR_W = 40,
  parameter int OFF_W  = 6,
  parameter int PAGE_W = 12,
  parameter int DEPTH  = 4,
  parameter int DEGREE = 2,
  parameter int GAP    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_enable,
  input  logic              io_mshr_avail,
  input  logic              io_req_val,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [1:0]        io_req_coh_state,
  input  logic              io_prefetch_ready,
  output logic              io_prefetch_valid,
  output logic [ADDR_W-1:0] io_prefetch_addr,
  output logic [4:0]        io_prefetch_cmd,
  output logic              io_busy,
  output logic [7:0]        io_drop_cnt
);

  localparam int LW  = ADDR_W - OFF_W;
  localparam int PGB = PAGE_W - OFF_W;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic          hint_q, hint_d;
  logic [2:0]    k_q, k_d;
  logic [LW-1:0] mem_line_q [DEPTH];
  logic          mem_hint_q [DEPTH];
  logic [PW:0]   wr_q, rd_q;
  logic [3:0]    gap_q;
  logic [7:0]    drop_q;
  logic [LW-1:0] last_q;
  logic          last_vld_q;

  logic [PW:0]   cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] slot_off;
  logic [LW-1:0] cand;
  logic          empty, full, gen, page_ok, hit, dup, push, drop, fire;
  logic          unused_addr;

  assign unused_addr = ^io_req_addr[OFF_W-1:0];

  assign cnt   = wr_q - rd_q;
  assign head  = rd_q[PW-1:0];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  assign gen     = (state_q == ST_GEN) && io_enable;
  assign cand    = line_q + LW'(k_q);
  assign page_ok = (cand[LW-1:PGB] == line_q[LW-1:PGB]);

  // Occupied slots only; the head counts even when it pops this cycle.
  always_comb begin
    hit      = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - head;
      if (({1'b0, slot_off} < cnt) && (mem_line_q[i] == cand))
        hit = 1'b1;
    end
  end

  assign dup  = hit || (last_vld_q && (last_q == cand));
  assign push = gen && page_ok && !dup && !full;
  assign drop = gen && page_ok && !dup && full;

  assign io_prefetch_valid = !empty && io_mshr_avail
                           && (gap_q == '0) && io_enable;
  assign fire = io_prefetch_valid && io_prefetch_ready;

  assign io_prefetch_addr = empty ? '0
                          : {mem_line_q[head], OFF_W'(0)};
  assign io_prefetch_cmd  = empty ? 5'h00
                          : (mem_hint_q[head] ? 5'h03 : 5'h02);
  assign io_busy     = (state_q == ST_GEN) || !empty;
  assign io_drop_cnt = drop_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    hint_d  = hint_q;
    k_d     = k_q;
    if (!io_enable) begin
      state_d = ST_IDLE;
    end else if (io_req_val) begin
      state_d = ST_GEN;
      line_d  = io_req_addr[ADDR_W-1:OFF_W];
      hint_d  = (io_req_coh_state == 2'd3);
      k_d     = 3'd1;
    end else if (state_q == ST_GEN) begin
      k_d = k_q + 3'd1;
      if (k_q == 3'(DEGREE))
        state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      hint_q     <= 1'b0;
      k_q        <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      gap_q      <= '0;
      drop_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_line_q[i] <= '0;
        mem_hint_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      hint_q  <= hint_d;
      k_q     <= k_d;
      if (!io_enable) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) begin
          mem_line_q[wr_q[PW-1:0]] <= cand;
          mem_hint_q[wr_q[PW-1:0]] <= hint_q;
          wr_q <= wr_q + 1'b1;
        end
        if (fire)
          rd_q <= rd_q + 1'b1;
      end
      if (fire) begin
        last_q     <= mem_line_q[head];
        last_vld_q <= 1'b1;
        gap_q      <= 4'(GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 4'd1;
      end
      if (drop && (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_prefetch_issue_scheduler.sv
// Directed bench for prefetch_issue_scheduler: per-cycle vector table
// followed by hand-written dedup, overflow, gating, reset, disable cases.
module tb_prefetch_issue_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, mshr = 1'b0, rv = 1'b0, rdy = 1'b0;
  logic [39:0] raddr = '0;
  logic [1:0]  coh = '0;
  logic        pv, busy;
  logic [39:0] pa;
  logic [4:0]  pcmd;
  logic [7:0]  dcnt;

  int errors = 0;
  int checks = 0;

  logic [39:0] fa [$];
  logic [4:0]  fc [$];

  prefetch_issue_scheduler dut (
    .clock(clock), .reset(reset), .io_enable(en),
    .io_mshr_avail(mshr), .io_req_val(rv), .io_req_addr(raddr),
    .io_req_coh_state(coh), .io_prefetch_ready(rdy),
    .io_prefetch_valid(pv), .io_prefetch_addr(pa),
    .io_prefetch_cmd(pcmd), .io_busy(busy), .io_drop_cnt(dcnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic [39:0] addr;
    logic [1:0]  coh;
    logic        v;
    logic [39:0] pa;
    logic [4:0]  cmd;
    logic        busy;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Starts at a negedge, samples each cycle, ends at a negedge.
  task automatic collect(input int n);
    fa.delete();
    fc.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      if (pv && rdy) begin
        fa.push_back(pa);
        fc.push_back(pcmd);
      end
      @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic trig(input logic [39:0] a, input logic [1:0] c);
    rv = 1'b1; raddr = a; coh = c;
    @(negedge clock);
    rv = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 40'h80001040, 2'd1, 1'b0, 40'h0, 5'h00, 1'b0};
    vt[1]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b1};
    vt[2]  = '{1'b0, 40'h0, 2'd0, 1'b1, 40'h80001080, 5'h02, 1'b1};
    vt[3]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h800010C0, 5'h02, 1'b1};
    vt[4]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h800010C0, 5'h02, 1'b1};
    vt[5]  = '{1'b0, 40'h0, 2'd0, 1'b1, 40'h800010C0, 5'h02, 1'b1};
    vt[6]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b0};
    vt[7]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b0};
    vt[8]  = '{1'b1, 40'h80001FC0, 2'd1, 1'b0, 40'h0, 5'h00, 1'b0};
    vt[9]  = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b1};
    vt[10] = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b1};
    vt[11] = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b0};
    vt[12] = '{1'b0, 40'h0, 2'd0, 1'b0, 40'h0, 5'h00, 1'b0};

    #1;
    chk("rst_valid", pv, 0);
    chk("rst_addr", pa, 0);
    chk("rst_cmd", pcmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", dcnt, 0);
    idle(3);
    reset = 1'b1; en = 1'b1; mshr = 1'b1; rdy = 1'b1;
    @(negedge clock);

    // Single trigger then page-boundary trigger, cycle by cycle.
    for (int i = 0; i < 13; i++) begin
      rv = vt[i].rv; raddr = vt[i].addr; coh = vt[i].coh;
      #1;
      chk($sformatf("vec%0d_valid", i), pv, vt[i].v);
      chk($sformatf("vec%0d_addr", i), pa, vt[i].pa);
      chk($sformatf("vec%0d_cmd", i), pcmd, vt[i].cmd);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      @(negedge clock);
    end
    rv = 1'b0;

    // Dedup: overlapping triggers share lines 2080.
    rdy = 1'b0;
    trig(40'h80002000, 2'd0);
    @(negedge clock);
    trig(40'h80002040, 2'd0);
    idle(4);
    #1;
    chk("dedup_busy", busy, 1);
    chk("dedup_drop", dcnt, 0);
    @(negedge clock);
    rdy = 1'b1;
    collect(12);
    chk("dedup_nfire", fa.size(), 3);
    if (fa.size() == 3) begin
      chk("dedup_f0", fa[0], 40'h80002040);
      chk("dedup_f1", fa[1], 40'h80002080);
      chk("dedup_f2", fa[2], 40'h800020C0);
      chk("dedup_cmd", {fc[0], fc[1], fc[2]}, {5'h02, 5'h02, 5'h02});
    end
    #1;
    chk("dedup_idle", busy, 0);
    @(negedge clock);

    // Overflow: four pages, two candidates each, FIFO holds four.
    rdy = 1'b0;
    for (int p = 3; p <= 6; p++) begin
      trig(40'h100 | (40'(p) << 12), 2'd0);
      idle(2);
    end
    idle(2);
    #1;
    chk("ovf_drop", dcnt, 4);
    chk("ovf_busy", busy, 1);
    chk("ovf_head", pa, 40'h3140);
    @(negedge clock);
    rdy = 1'b1;
    collect(16);
    chk("ovf_nfire", fa.size(), 4);
    if (fa.size() == 4) begin
      chk("ovf_f0", fa[0], 40'h3140);
      chk("ovf_f1", fa[1], 40'h3180);
      chk("ovf_f2", fa[2], 40'h4140);
      chk("ovf_f3", fa[3], 40'h4180);
    end

    // Dirty hint held back by MSHR availability.
    mshr = 1'b0;
    trig(40'h7000, 2'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mshr_gate%0d", i), pv, 0);
      @(negedge clock);
    end
    mshr = 1'b1;
    #1;
    chk("dirty_valid", pv, 1);
    chk("dirty_addr", pa, 40'h7040);
    chk("dirty_cmd", pcmd, 5'h03);
    collect(8);
    chk("dirty_nfire", fa.size(), 2);
    if (fa.size() == 2) begin
      chk("dirty_f1", fa[1], 40'h7080);
      chk("dirty_cmd1", fc[1], 5'h03);
    end
    idle(2);

    // Asynchronous reset mid-generation with a queued entry.
    rdy = 1'b0;
    trig(40'h8000, 2'd0);
    @(negedge clock);
    #1;
    chk("prerst_valid", pv, 1);
    chk("prerst_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", pv, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", pa, 0);
    chk("arst_cmd", pcmd, 0);
    chk("arst_drop", dcnt, 0);
    @(negedge clock);
    reset = 1'b1;
    rdy = 1'b1;
    collect(10);
    chk("postrst_nfire", fa.size(), 0);

    // Disable drops valid at once and flushes the FIFO.
    rdy = 1'b0;
    trig(40'h9000, 2'd0);
    idle(3);
    #1;
    chk("predis_valid", pv, 1);
    @(negedge clock);
    en = 1'b0;
    #1;
    chk("dis_valid", pv, 0);
    @(negedge clock);
    en = 1'b1;
    #1;
    chk("dis_flush_busy", busy, 0);
    chk("dis_flush_valid", pv, 0);
    @(negedge clock);
    rdy = 1'b1;
    collect(4);
    chk("dis_nfire", fa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_issue_scheduler.md
# prefetch_issue_scheduler

Sequences next-line prefetch requests into the data-cache prefetch port. It sits between the dcache miss-request observation point and the MSHR prefetch input. It converts each observed miss into up to DEGREE line-granular candidates, deduplicates them, buffers them in a small FIFO, and issues them one at a time. Issue happens only when an MSHR is available and a minimum inter-issue gap has elapsed.

## Interface
Parameters:
- ADDR_W, 40, physical address width
- OFF_W, 6, line-offset bits (64 B lines)
- PAGE_W, 12, page-offset bits; candidates never cross a page
- DEPTH, 4, candidate FIFO entries (power of two)
- DEGREE, 2, lines ahead generated per trigger (1..7)
- GAP, 2, minimum idle cycles between consecutive issues (0..15)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- io_enable  in  1  scheduler enable
- io_mshr_avail  in  1  at least one MSHR free
- io_req_val  in  1  miss observed this cycle (trigger)
- io_req_addr  in  ADDR_W  miss address
- io_req_coh_state  in  2  line coherence state at miss (3 = Dirty)
- io_prefetch_ready  in  1  cache accepts prefetch
- io_prefetch_valid  out  1  prefetch request valid
- io_prefetch_addr  out  ADDR_W  line-aligned prefetch address (low OFF_W bits zero)
- io_prefetch_cmd  out  5  5'h02 prefetch-read, 5'h03 prefetch-write
- io_busy  out  1  generator active or FIFO non-empty
- io_drop_cnt  out  8  saturating count of candidates dropped because the FIFO was full

## Operation
**Generator FSM** has two states, IDLE and GEN.
- IDLE to GEN: on io_req_val && io_enable. The scheduler latches trigger line = io_req_addr[ADDR_W-1:OFF_W], page = io_req_addr[ADDR_W-1:PAGE_W], write-hint = (io_req_coh_state == 3), and sets k = 1.
- In GEN, the scheduler forms one candidate per cycle: line + k.
  - The candidate is discarded if its page differs from the latched page.
  - It is discarded if it equals any valid FIFO entry, including the head being popped this cycle.
  - It is discarded if it equals the last-issued line register.
  - Otherwise it is pushed. If the FIFO is full (occupancy before this cycle's pop == DEPTH), it is dropped instead and io_drop_cnt increments, saturating at 8'hFF.
- k increments after each candidate. GEN to IDLE after k == DEGREE has been processed.
- A new io_req_val while in GEN re-latches the trigger and restarts at k = 1. The remaining candidates of the old trigger are abandoned. The latest trigger wins.
- The write-hint is stored per FIFO entry. io_prefetch_cmd = hint ? 5'h03 : 5'h02.

**Issue**
- io_prefetch_valid = FIFO non-empty && io_mshr_avail && gap_cnt == 0 && io_enable.
- The head address and command are driven from FIFO storage and are stable while the head is unchanged.
- Valid may drop without a fire if io_mshr_avail falls. This is permitted.
- Fire = valid && io_prefetch_ready. On fire:
  - pop the head;
  - load the last-issued line register;
  - load gap_cnt = GAP.
- gap_cnt decrements by 1 each cycle while nonzero.

**Disable**
- io_enable low forces the FSM to IDLE and forces valid low in the same cycle.
- The FIFO is cleared on the next edge.
- gap_cnt and io_drop_cnt are retained.

**Arithmetic**
- Line addition uses ADDR_W-OFF_W bits and wraps modulo 2^(ADDR_W-OFF_W).
- A wrapped candidate always changes page, so it is discarded by the page check.

## Timing
- Reset (asynchronous assert, clock-synchronous effect on release) sets:
  - FSM to IDLE, FIFO empty, gap_cnt = 0, drop_cnt = 0;
  - last-issued register invalid, all outputs 0.
- Trigger in cycle T: first candidate is evaluated in T+1 and becomes visible at the FIFO head in T+2. Earliest io_prefetch_valid is T+2.
- The k-th candidate is evaluated in cycle T+k.
- Fire in cycle F: the next issue is allowed no earlier than F+GAP+1.
- A push and a pop in the same cycle are both performed. Full status for a push uses occupancy before the pop.
- Trigger and fire may coincide. They are independent.

## Test plan
- **Single trigger:** req_addr = 40'h80001040, coh 1, mshr_avail = 1, ready = 1.
  - Fires at 40'h80001080, then at 40'h800010C0 three cycles later (GAP = 2).
  - Both fires use cmd 5'h02.
- **Page boundary:** req_addr = 40'h80001FC0. Exactly zero fires and io_busy returns to 0 after DEGREE cycles.
- **Dedup:** triggers at 40'h80002000, then 40'h80002040 two cycles later, with ready = 0.
  - FIFO holds lines 0x..2040, 0x..2080, 0x..20C0 once each; no duplicates.
  - Raising ready yields 3 fires in order.
- **Overflow:** ready = 0, four triggers on distinct pages. FIFO holds 4 entries and io_drop_cnt = 4.
- **Dirty hint and MSHR gating:** trigger with coh 3 while mshr_avail = 0.
  - Valid stays 0.
  - Raising mshr_avail produces valid with cmd 5'h03.
- **Reset and disable:**
  - Assert reset mid-GEN with a non-empty FIFO. All outputs go to 0 immediately and no fire follows release.
  - Dropping io_enable with a non-empty FIFO forces valid to 0 the same cycle. The FIFO is empty afterwards.
